// File: rtl/player_direction_encoder.sv
// Debounced four-key direction encoder.
// Turns raw active-low buttons into a single latest-wins direction request.
module player_direction_encoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] keys,
    input  logic       ack,
    output logic [1:0] direction_req,
    output logic       req_valid,
    output logic [3:0] pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [CW-1:0] cnt [4];
    logic [3:0]    pressed_d;
    logic [3:0]    press_ev;
    logic [3:0]    win;
    logic [1:0]    win_code;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~keys;
            sync2 <= sync1;
        end
    end

    // Counter tracks how long the synced level has disagreed with pressed.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            pressed <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == pressed[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] + CW'(1) == CMAX) begin
                    cnt[i]     <= '0;
                    pressed[i] <= ~pressed[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pressed_d <= '0;
        end else begin
            pressed_d <= pressed;
        end
    end

    assign press_ev = pressed & ~pressed_d;
    // Isolate the lowest set bit: UP (bit 0) has top priority.
    assign win = press_ev & (~press_ev + 4'd1);

    always_comb begin
        win_code = 2'b00;
        unique case (1'b1)
            win[0]:  win_code = 2'b00;
            win[1]:  win_code = 2'b01;
            win[2]:  win_code = 2'b11;
            win[3]:  win_code = 2'b10;
            default: win_code = 2'b00;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            direction_req <= 2'b00;
            req_valid     <= 1'b0;
        end else if (|press_ev) begin
            direction_req <= win_code;
            req_valid     <= 1'b1;
        end else if (ack) begin
            req_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_player_direction_encoder.sv
// Bench for player_direction_encoder: vector table plus corner sequences.
// A monitor pops expected {code, cycle} records as requests appear.
module tb_player_direction_encoder;

    localparam int D = 16;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [3:0] keys     = 4'hF;
    logic       ack      = 1'b0;
    logic [1:0] direction_req;
    logic       req_valid;
    logic [3:0] pressed;

    player_direction_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .keys          (keys),
        .ack           (ack),
        .direction_req (direction_req),
        .req_valid     (req_valid),
        .pressed       (pressed)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [3:0] keys;
        int         hold;
        logic [3:0] exp_pressed;
        bit         exp_req;
        logic [1:0] exp_code;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[9];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic       pv = 1'b0;
    logic [1:0] pd = 2'b00;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic push(input logic [1:0] code);
        exp_t e;
        e.code = code;
        e.cyc  = cyc + 1 + D + 2;
        sb.push_back(e);
    endtask

    task automatic ack_pulse;
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // New request = valid rising, or the code changing while valid.
    always @(posedge CLOCK_50) begin
        #1;
        if (req_valid && (!pv || direction_req != pd)) begin
            if (sb.size() == 0) begin
                chk("unexpected_request", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("req_code", int'(direction_req), int'(e.code));
                chk("req_cycle", cyc, e.cyc);
            end
        end
        pv = req_valid;
        pd = direction_req;
    end

    initial begin
        int t;
        tbl[0] = '{4'b1110, D + 4, 4'b0001, 1'b1, 2'b00};
        tbl[1] = '{4'b0111, 10,    4'b0000, 1'b0, 2'b00};
        tbl[2] = '{4'b1110, D - 1, 4'b0000, 1'b0, 2'b00};
        tbl[3] = '{4'b0101, D + 4, 4'b1010, 1'b1, 2'b01};
        tbl[4] = '{4'b1101, D + 4, 4'b0010, 1'b1, 2'b01};
        tbl[5] = '{4'b1011, D + 4, 4'b0100, 1'b1, 2'b11};
        tbl[6] = '{4'b0111, D + 4, 4'b1000, 1'b1, 2'b10};
        tbl[7] = '{4'b0000, D + 4, 4'b1111, 1'b1, 2'b00};
        tbl[8] = '{4'b1111, D + 4, 4'b0000, 1'b0, 2'b00};

        #5;
        chk("rst_pressed", int'(pressed), 0);
        chk("rst_valid", int'(req_valid), 0);
        chk("rst_dir", int'(direction_req), 0);
        repeat (2) tick();
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            keys = tbl[i].keys;
            if (tbl[i].exp_req) push(tbl[i].exp_code);
            repeat (tbl[i].hold) tick();
            chk("vec_pressed", int'(pressed), int'(tbl[i].exp_pressed));
            chk("vec_valid", int'(req_valid), int'(tbl[i].exp_req));
            if (tbl[i].exp_req) begin
                chk("vec_dir", int'(direction_req), int'(tbl[i].exp_code));
                ack_pulse();
                chk("vec_ack_valid", int'(req_valid), 0);
                chk("vec_ack_dir", int'(direction_req), int'(tbl[i].exp_code));
            end
            keys = 4'hF;
            repeat (D + 4) tick();
            chk("vec_rel_pressed", int'(pressed), 0);
            chk("vec_rel_valid", int'(req_valid), 0);
        end

        // Exactly D low samples is just enough to register a press.
        keys = 4'b1110;
        push(2'b00);
        repeat (D) tick();
        keys = 4'hF;
        repeat (2 * D + 6) tick();
        chk("pulseD_pressed", int'(pressed), 0);
        chk("pulseD_valid", int'(req_valid), 1);
        ack_pulse();
        chk("pulseD_ack", int'(req_valid), 0);

        // Overwrite while pending, then event coincident with ack.
        keys = 4'b1110;
        push(2'b00);
        repeat (D + 4) tick();
        keys = 4'b1010;
        push(2'b11);
        repeat (D + 4) tick();
        chk("ovr_dir", int'(direction_req), 3);
        chk("ovr_valid", int'(req_valid), 1);
        keys = 4'b0010;
        t = cyc + 1 + D + 2;
        push(2'b10);
        while (cyc < t - 1) tick();
        ack_pulse();
        chk("ackev_valid", int'(req_valid), 1);
        chk("ackev_dir", int'(direction_req), 2);
        tick();
        ack_pulse();
        chk("ack_clear", int'(req_valid), 0);
        chk("ack_hold_dir", int'(direction_req), 2);
        ack_pulse();
        chk("ack_idle", int'(req_valid), 0);
        keys = 4'hF;
        repeat (D + 4) tick();

        // Asynchronous reset mid-debounce with a request pending.
        keys = 4'b1110;
        push(2'b00);
        repeat (D + 4) tick();
        keys = 4'b1100;
        repeat (11) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", int'(req_valid), 0);
        chk("arst_dir", int'(direction_req), 0);
        chk("arst_pressed", int'(pressed), 0);
        repeat (3) tick();
        reset = 1'b0;
        push(2'b00);
        repeat (D + 4) tick();
        chk("post_rst_pressed", int'(pressed), 3);
        chk("post_rst_valid", int'(req_valid), 1);
        ack_pulse();
        keys = 4'hF;
        repeat (D + 4) tick();

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/player_direction_encoder.md
PLAYER_DIRECTION_ENCODER -- requirements
Module: player_direction_encoder

Interface
REQ-001 The block SHALL have a parameter DEBOUNCE_CYCLES, default 16, giving the number of consecutive sampled cycles a changed key level must persist before it is accepted (legal range 1..2^20).
REQ-002 Port CLOCK_50  input  1  the single system clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port keys  input  4  raw, asynchronous, active-low buttons: [0]=UP, [1]=RIGHT, [2]=DOWN, [3]=LEFT.
REQ-005 Port ack  input  1  consumer accepts the current request while it is high.
REQ-006 Port direction_req  output  2  requested direction code: 00=UP, 01=RIGHT, 11=DOWN, 10=LEFT.
REQ-007 Port req_valid  output  1  high while direction_req holds an unconsumed request.
REQ-008 Port pressed  output  4  debounced pressed state per key, active-high, with the same bit order as keys.

Function
REQ-009 Each keys bit SHALL pass through a two-flop synchronizer, inverted to active-high, before any other use.
REQ-010 Each key SHALL have an independent debounce counter of width ceil(log2(DEBOUNCE_CYCLES+1)); the counter increments on every edge where the synchronized level differs from pressed[i], and clears on any edge where they agree.
REQ-011 pressed[i] SHALL toggle on the edge at which its counter would reach DEBOUNCE_CYCLES; the counter clears on that same edge.
REQ-012 A press event for key i SHALL be generated when pressed[i] is high and was low on the previous cycle; releases SHALL generate no event.
REQ-013 A key held indefinitely SHALL produce exactly one press event.
REQ-014 Multiple press events in the same cycle SHALL resolve by fixed priority UP > RIGHT > DOWN > LEFT; lower-priority events in that cycle SHALL be discarded.
REQ-015 On a winning event, the block SHALL load direction_req with the encoded code and set req_valid on the next edge; event-to-output latency SHALL be 1 cycle.
REQ-016 If req_valid is high and ack is high with no event, req_valid SHALL clear on the next edge and direction_req SHALL hold its value.
REQ-017 If an event occurs in the same cycle as ack, the new code SHALL load and req_valid SHALL remain high.
REQ-018 If an event occurs while req_valid is high and ack is low, the new code SHALL overwrite direction_req (latest wins) and req_valid SHALL stay high.
REQ-019 ack while req_valid is low SHALL be ignored.
REQ-020 The block SHALL NOT filter reversal requests; reversal filtering belongs to the downstream direction register.
REQ-021 End-to-end latency SHALL be fixed: for a key first sampled low at edge k and held, req_valid SHALL be high after edge k+DEBOUNCE_CYCLES+2.
REQ-022 A level change that persists for fewer than DEBOUNCE_CYCLES synchronized samples SHALL leave pressed and req_valid unchanged.

Reset
REQ-023 While reset is high, the block SHALL clear synchronizers (to released), counters, pressed, and the event history to 0; direction_req SHALL be 00 and req_valid SHALL be 0.
REQ-024 Reset asserted mid-debounce or with a pending request SHALL discard all progress immediately, without waiting for a clock edge.
REQ-025 A key held through reset deassertion SHALL be treated as a new press and SHALL produce one request after the REQ-021 latency, measured from the first edge after deassertion.

Verification
REQ-026 D=16, keys=1110 held from edge 10 -> pressed=0001 and req_valid=1 with direction_req=00 after edge 28; ack pulsed at edge 30 -> req_valid=0 after edge 30 and direction_req stays 00.
REQ-027 D=16, keys[3] low for 10 cycles then high -> pressed, req_valid and direction_req unchanged throughout.
REQ-028 D=16, keys=0101 (RIGHT and LEFT) going low on the same edge -> single request direction_req=01; no LEFT request follows while both keys are held.
REQ-029 Pending UP with ack low, then a DOWN event -> direction_req=11 and req_valid stays 1; ack together with a new LEFT event -> direction_req=10 and req_valid stays 1.
REQ-030 reset pulsed asynchronously between edges while a request is pending and a counter is at 9 -> outputs are 0 immediately; a key held through reset yields one request at deassertion+D+2.
